// File: rtl/wc_scan_pkg.sv
// rtl/wc_scan_pkg.sv - shared types and default sizes for the wildcard scan controller
// Contents: WCS_W / WCS_N default key width and table depth,
//           wcs_state_t controller FSM states, wcs_entry_t table entry {en, val, mask}.
package wc_scan_pkg;

   localparam int WCS_W = 8;
   localparam int WCS_N = 8;

   typedef enum logic [1:0] {
      WCS_IDLE = 2'd0,
      WCS_SCAN = 2'd1,
      WCS_RESP = 2'd2
   } wcs_state_t;

   typedef struct packed {
      logic             en;
      logic [WCS_W-1:0] val;
      logic [WCS_W-1:0] mask;
   } wcs_entry_t;

endpackage

// File: rtl/wc_compare.sv
// rtl/wc_compare.sv - combinational wildcard comparator for one table entry
// Ports: key   lookup key
//        val   pattern value
//        mask  don't-care mask (1 = bit ignored)
//        en    entry enable; a disabled entry never matches
//        match 1 when every cared-about bit of key equals val
module wc_compare #(
   parameter int W = 8
) (
   input  logic [W-1:0] key,
   input  logic [W-1:0] val,
   input  logic [W-1:0] mask,
   input  logic         en,
   output logic         match
);

   assign match = en && (((key ^ val) & ~mask) == '0);

endmodule

// File: rtl/wc_scan_ctrl.sv
// rtl/wc_scan_ctrl.sv - sequential lowest-index wildcard lookup over a small pattern table
// Ports: clk, rst_n                       clock, synchronous active-low reset
//        cfg_we/cfg_idx/cfg_en/cfg_val/cfg_mask   table entry write port
//        q_valid/q_ready/q_key            query handshake and key
//        r_valid/r_ready/r_hit/r_idx      result handshake, hit flag, lowest matching index
//        busy                             controller not idle
// Build option: WC_SCAN_EARLY_EXIT_EN ends the scan on the first matching entry.
module wc_scan_ctrl
   import wc_scan_pkg::*;
#(
   parameter int W    = WCS_W,
   parameter int N    = WCS_N,
   parameter int IDXW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cfg_we,
   input  logic [IDXW-1:0] cfg_idx,
   input  logic            cfg_en,
   input  logic [W-1:0]    cfg_val,
   input  logic [W-1:0]    cfg_mask,
   input  logic            q_valid,
   output logic            q_ready,
   input  logic [W-1:0]    q_key,
   output logic            r_valid,
   input  logic            r_ready,
   output logic            r_hit,
   output logic [IDXW-1:0] r_idx,
   output logic            busy
);

`ifdef WC_SCAN_EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

   logic            en_q   [N];
   logic [W-1:0]    val_q  [N];
   logic [W-1:0]    mask_q [N];

   wcs_state_t      state_q, state_d;
   logic [W-1:0]    key_q;
   logic [IDXW-1:0] scan_idx_q;
   logic            q_ready_q, r_valid_q, r_hit_q, busy_q;
   logic [IDXW-1:0] r_idx_q;
   logic            accept;
   logic            cmp_match;

   // The comparator reads registered table contents, so a write landing on
   // the entry being compared this cycle is only seen by later lookups.
   wc_compare #(.W(W)) u_cmp (
      .key   (key_q),
      .val   (val_q[scan_idx_q]),
      .mask  (mask_q[scan_idx_q]),
      .en    (en_q[scan_idx_q]),
      .match (cmp_match)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            en_q[i]   <= 1'b0;
            val_q[i]  <= '0;
            mask_q[i] <= '0;
         end
      end else if (cfg_we && (int'(cfg_idx) < N)) begin
         en_q[cfg_idx]   <= cfg_en;
         val_q[cfg_idx]  <= cfg_val;
         mask_q[cfg_idx] <= cfg_mask;
      end
   end

   // q_ready is registered, so the first cycle out of reset reports not-ready
   // even though the FSM already sits in IDLE; accept only on a real handshake.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         WCS_IDLE: begin
            if (q_valid && q_ready_q) begin
               state_d = WCS_SCAN;
               accept  = 1'b1;
            end
         end
         WCS_SCAN: begin
            if ((EARLY_EXIT && cmp_match) || (scan_idx_q == LAST_IDX)) begin
               state_d = WCS_RESP;
            end
         end
         WCS_RESP: begin
            if (r_ready) begin
               state_d = WCS_IDLE;
            end
         end
         default: state_d = WCS_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= WCS_IDLE;
         key_q      <= '0;
         scan_idx_q <= '0;
         q_ready_q  <= 1'b0;
         r_valid_q  <= 1'b0;
         busy_q     <= 1'b0;
         r_hit_q    <= 1'b0;
         r_idx_q    <= '0;
      end else begin
         state_q   <= state_d;
         q_ready_q <= (state_d == WCS_IDLE);
         r_valid_q <= (state_d == WCS_RESP);
         busy_q    <= (state_d != WCS_IDLE);

         if (accept) begin
            key_q      <= q_key;
            scan_idx_q <= '0;
            r_hit_q    <= 1'b0;
            r_idx_q    <= '0;
         end

         if (state_q == WCS_SCAN) begin
            // Only the first match is recorded; later hits keep the lower index.
            if (cmp_match && !r_hit_q) begin
               r_hit_q <= 1'b1;
               r_idx_q <= scan_idx_q;
            end
            // Stop at the last entry rather than wrapping, so N need not be 2**IDXW.
            if (scan_idx_q != LAST_IDX) begin
               scan_idx_q <= scan_idx_q + IDXW'(1);
            end
         end
      end
   end

   assign q_ready = q_ready_q;
   assign r_valid = r_valid_q;
   assign r_hit   = r_hit_q;
   assign r_idx   = r_idx_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_wc_scan_ctrl.sv
// tb/tb_wc_scan_ctrl.sv - randomized and directed check of wc_scan_ctrl against a table-level model
module tb_wc_scan_ctrl;
   import wc_scan_pkg::*;

   localparam int W    = 8;
   localparam int N    = 8;
   localparam int IDXW = 3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            cfg_we = 1'b0;
   logic [IDXW-1:0] cfg_idx = '0;
   logic            cfg_en = 1'b0;
   logic [W-1:0]    cfg_val = '0;
   logic [W-1:0]    cfg_mask = '0;
   logic            q_valid = 1'b0;
   logic            q_ready;
   logic [W-1:0]    q_key = '0;
   logic            r_valid;
   logic            r_ready = 1'b0;
   logic            r_hit;
   logic [IDXW-1:0] r_idx;
   logic            busy;

   int n_tests = 0;
   int n_fail  = 0;

   wcs_entry_t m_tbl [N];

   wc_scan_ctrl #(.W(W), .N(N), .IDXW(IDXW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_we   (cfg_we),
      .cfg_idx  (cfg_idx),
      .cfg_en   (cfg_en),
      .cfg_val  (cfg_val),
      .cfg_mask (cfg_mask),
      .q_valid  (q_valid),
      .q_ready  (q_ready),
      .q_key    (q_key),
      .r_valid  (r_valid),
      .r_ready  (r_ready),
      .r_hit    (r_hit),
      .r_idx    (r_idx),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit ent_match(input wcs_entry_t e, input logic [W-1:0] key);
      for (int b = 0; b < W; b++) begin
         if (!e.mask[b] && (key[b] != e.val[b])) return 1'b0;
      end
      return e.en;
   endfunction

   function automatic wcs_entry_t mk(input logic en, input logic [W-1:0] val, input logic [W-1:0] mask);
      wcs_entry_t e;
      e.en = en; e.val = val; e.mask = mask;
      return e;
   endfunction

   function automatic wcs_entry_t rnd_entry();
      return mk(1'($urandom_range(0, 1)), W'($urandom), W'($urandom & $urandom));
   endfunction

   task automatic cfg_write(input int idx, input wcs_entry_t e);
      cfg_we = 1'b1; cfg_idx = IDXW'(idx);
      cfg_en = e.en; cfg_val = e.val; cfg_mask = e.mask;
      @(posedge clk); @(negedge clk);
      cfg_we = 1'b0;
      m_tbl[idx] = e;
   endtask

   task automatic clear_model();
      for (int i = 0; i < N; i++) m_tbl[i] = mk(1'b0, '0, '0);
   endtask

   // Runs one query from a negedge. wr_cyc >= 0 drives one table write in the
   // cycle right after edge T+wr_cyc, i.e. the cycle entry wr_cyc is compared.
   task automatic run_query(input string tag, input logic [W-1:0] key, input int wr_cyc,
                            input int wr_idx, input wcs_entry_t wr_e, input int hold);
      int first, lat, w, c;
      bit wrote, done;
      logic exp_hit;
      logic [IDXW-1:0] exp_idx;
      wcs_entry_t e;

      first = -1;
      for (int k = 0; k < N; k++) begin
         e = (wr_cyc >= 0 && wr_cyc < k && wr_idx == k) ? wr_e : m_tbl[k];
         if (first < 0 && ent_match(e, key)) first = k;
      end
      exp_hit = (first >= 0);
      exp_idx = exp_hit ? IDXW'(first) : '0;
      lat = N + 1;
`ifdef WC_SCAN_EARLY_EXIT_EN
      if (first >= 0) lat = first + 2;
`endif

      w = 0;
      while (!q_ready && w < 20) begin
         @(posedge clk); @(negedge clk); w++;
      end
      if (!q_ready) chk({tag, "_qready_timeout"}, 0, 1);

      q_valid = 1'b1; q_key = key;
      @(posedge clk);
      wrote = 1'b0; done = 1'b0; c = 0;
      while (!done && c <= lat + hold + 1) begin
         @(negedge clk);
         q_valid = (c + 1 >= lat);
         cfg_we = (c == wr_cyc);
         if (c == wr_cyc) begin
            wrote = 1'b1; cfg_idx = IDXW'(wr_idx);
            cfg_en = wr_e.en; cfg_val = wr_e.val; cfg_mask = wr_e.mask;
         end
         chk({tag, "_rvalid"}, r_valid, (c + 1 >= lat));
         chk({tag, "_busy"}, busy, 1);
         chk({tag, "_qready_busy"}, q_ready, 0);
         if (c + 1 >= lat) begin
            chk({tag, "_hit"}, r_hit, exp_hit);
            chk({tag, "_idx"}, r_idx, exp_idx);
         end
         if (c + 1 - lat >= hold) begin
            r_ready = 1'b1; q_valid = 1'b0; done = 1'b1;
         end
         @(posedge clk);
         c++;
      end
      @(negedge clk);
      r_ready = 1'b0; cfg_we = 1'b0;
      chk({tag, "_qready_back"}, q_ready, 1);
      chk({tag, "_busy_back"}, busy, 0);
      chk({tag, "_rvalid_back"}, r_valid, 0);
      if (wrote) m_tbl[wr_idx] = wr_e;
   endtask

   initial begin
      wcs_entry_t nul, e;
      logic [W-1:0] key;
      int wc;

      clear_model();
      nul = mk(1'b0, '0, '0);

      rst_n = 1'b0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      chk("rst_qready", q_ready, 0);
      chk("rst_rvalid", r_valid, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("idle_qready", q_ready, 1);
      chk("idle_rvalid", r_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_hit", r_hit, 0);
      chk("idle_idx", r_idx, 0);

      run_query("miss_all", 8'hA5, -1, 0, nul, 0);

      cfg_write(3, mk(1'b1, 8'hA0, 8'h0F));
      cfg_write(5, mk(1'b1, 8'hA5, 8'h00));
      run_query("hit3", 8'hA5, -1, 0, nul, 0);
      run_query("hold4", 8'hA5, -1, 0, nul, 4);
      run_query("wr_same", 8'hA5, 3, 3, mk(1'b0, 8'hA0, 8'h0F), 0);
      run_query("after_wr", 8'hA5, -1, 0, nul, 1);

      for (int i = 0; i < N; i++) cfg_write(i, nul);
      cfg_write(7, mk(1'b1, 8'h00, 8'hFF));
      run_query("any7", 8'h3C, -1, 0, nul, 0);

      q_valid = 1'b1; q_key = 8'h11;
      @(posedge clk); @(negedge clk);
      q_valid = 1'b0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      clear_model();
      @(posedge clk); @(negedge clk);
      chk("abort_qready", q_ready, 1);
      chk("abort_busy", busy, 0);
      for (int i = 0; i < N + 4; i++) begin
         chk("abort_rvalid", r_valid, 0);
         @(posedge clk); @(negedge clk);
      end
      run_query("cleared", 8'h3C, -1, 0, nul, 0);

      for (int it = 0; it < 30; it++) begin
         for (int j = $urandom_range(0, 3); j > 0; j--) cfg_write($urandom_range(0, N - 1), rnd_entry());
         if ($urandom_range(0, 1) == 1) begin
            e = m_tbl[$urandom_range(0, N - 1)];
            key = e.val ^ (W'($urandom) & e.mask);
         end else begin
            key = W'($urandom);
         end
         wc = ($urandom_range(0, 2) == 0) ? $urandom_range(0, N - 1) : -1;
         run_query("rnd", key, wc, $urandom_range(0, N - 1), rnd_entry(), $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wc_scan_ctrl.md
# wc_scan_ctrl

Sequencer that shares one wildcard comparator (`==?`-style: key bits compared only where the pattern cares) across a small pattern table. It accepts one lookup key at a time over a valid/ready handshake, walks the table one entry per cycle, and returns the lowest-index matching entry over a second valid/ready handshake. It sits in front of the lint-example datapath as its controller. The pattern table is written through a side configuration port.

## Interface
- `W`, 8, key/pattern width in bits
- `N`, 8, number of table entries (≥2)
- `IDXW`, `$clog2(N)`, entry index width

- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `cfg_we`  in  1  table write strobe
- `cfg_idx`  in  IDXW  entry written
- `cfg_en`  in  1  entry enable written
- `cfg_val`  in  W  pattern value written
- `cfg_mask`  in  W  don't-care mask written (1 = ignore bit)
- `q_valid`  in  1  query key valid
- `q_ready`  out  1  controller can accept a query
- `q_key`  in  W  lookup key
- `r_valid`  out  1  result valid
- `r_ready`  in  1  result consumer ready
- `r_hit`  out  1  at least one enabled entry matched
- `r_idx`  out  IDXW  lowest matching index (0 when `r_hit`=0)
- `busy`  out  1  FSM not in IDLE

## Operation
- Match rule for entry i: `en[i] && ((q_key ^ val[i]) & ~mask[i]) == 0`. A disabled entry never matches. An all-ones mask matches any key.
- FSM states:
  - IDLE: `q_ready`=1. On `q_valid`, latch the key, clear the hit register, set scan index to 0, and go to SCAN.
  - SCAN: compare the entry at the scan index against the latched key. The first match records `r_hit`=1 and `r_idx`=index; later matches are ignored. After index N-1, go to RESP.
  - RESP: `r_valid`=1. Hold `r_hit` and `r_idx` stable until `r_valid && r_ready`, then go to IDLE.
- `q_ready` is 0 in SCAN and RESP. Back-to-back queries are not overlapped.
- Table writes are accepted in every state and become visible the cycle after `cfg_we`.
  - If a write and a compare hit the same entry in the same cycle, the compare uses the old contents.
  - Writing an entry that has already been scanned does not alter the pending result.
- Scan-index arithmetic is unsigned IDXW bits. The index never wraps: the terminal test is index == N-1, and N need not be a power of two.
- Reset values: `q_ready`=0 during reset, then 1 in IDLE. `r_valid`, `r_hit`, `r_idx`, `busy` = 0. All table `en`, `val`, `mask` = 0. FSM = IDLE.
- A reset asserted mid-SCAN or mid-RESP aborts the query. No response is ever produced for it.

## Timing
- Query accepted at edge T, meaning `q_valid && q_ready` is sampled at T.
- SCAN occupies cycles T+1 … T+N, with entry k compared in cycle T+1+k.
- `r_valid` rises at T+N+1 without early exit.
- RESP lasts at least 1 cycle. If `r_ready`=1 when `r_valid` rises, `q_ready` returns at T+N+2.
- `busy` = !IDLE. Its timing is identical to `!q_ready` out of reset.
- All outputs are registered. There is no combinational path from `q_valid` or `r_ready` to any output.

## Configuration
- `WC_SCAN_EARLY_EXIT_EN`
  - Defined: SCAN goes to RESP on the first matching entry k, so `r_valid` rises at T+k+2. A miss still takes the full N cycles.
  - Undefined: fixed-latency full scan as described above. Results are identical in both modes; only latency differs.

## Structure
- Shared package `wc_scan_pkg`:
  - FSM state enum (`WCS_IDLE`, `WCS_SCAN`, `WCS_RESP`)
  - entry struct `{en, val, mask}`
  - default `W`/`N` localparams
- One sub-module, `wc_compare`: purely combinational, `(key, val, mask, en) -> match`. It is instantiated once and shared by the scan.
- Everything else (table registers, FSM, index counter, result registers) lives in `wc_scan_ctrl`.

## Test plan
- Reset, then check all outputs: `q_ready`=1, `r_valid`=0, `busy`=0. Query 8'hA5 with all entries disabled -> `r_hit`=0, `r_idx`=0, `r_valid` at T+9 (N=8).
- Entry 3 = {en=1, val=8'hA0, mask=8'h0F}, entry 5 = {1, 8'hA5, 8'h00}. Query 8'hA5 -> `r_hit`=1, `r_idx`=3. With `WC_SCAN_EARLY_EXIT_EN`, `r_valid` at T+5.
- Hold `r_ready`=0 for 4 cycles in RESP -> `r_valid`, `r_hit`, `r_idx` stable, `q_ready`=0, and a new `q_valid` is not accepted.
- During SCAN of the same query, write entry 3 `en`=0 in the cycle it is compared -> still `r_idx`=3. A follow-up query 8'hA5 -> `r_idx`=5.
- Entry 7 = {1, 8'h00, 8'hFF}, others disabled. Query 8'h3C -> `r_hit`=1, `r_idx`=7, `r_valid` at T+9 in both modes.
- Assert `rst_n`=0 for 1 cycle mid-SCAN -> no `r_valid` ever appears for that query. Next cycle after release, IDLE with `q_ready`=1 and the table cleared.
